// File: rtl/cmd_encoder.sv
// cmd_encoder: keypad-to-command producer for the engine command stream.
// Filters keys against the current game mode, queues legal command words in
// a register-array FIFO and hands them to the engine over valid/ready with a
// running command address that tracks the engine's command pointer.
module cmd_encoder #(
    parameter int DEPTH      = 8,
    parameter int ADDR_LIMIT = 2001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    input  logic                     on_enemy,
    input  logic                     can_hacks,
    input  logic                     flush,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [15:0]              cmd_data,
    output logic [15:0]              cmd_addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               reject_count,
    output logic [7:0]               drop_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [15:0]     ADDR_MAX = 16'(ADDR_LIMIT - 1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          key_legal;
    logic [15:0]   key_word;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop_ev;
    logic          reject_ev;

    // Decode keypad code into legality for the current mode and its command word
    always_comb begin
        key_legal = 1'b0;
        key_word  = {12'h000, key_code};
        case (key_code)
            4'h1, 4'h2, 4'h3, 4'h4: key_legal = !on_enemy;
            4'h5, 4'h6:             key_legal = on_enemy;
            4'hA: begin
                key_legal = can_hacks;
                key_word  = 16'h0010;
            end
            default:                key_legal = 1'b0;
        endcase
    end

    assign full      = (fifo_count == FULL_CNT);
    assign cmd_valid = (fifo_count != '0);
    assign cmd_data  = mem[rd_ptr];

    // A flush cancels both the pop and the push of the same cycle; a full FIFO
    // still accepts a key when the head leaves in that same cycle.
    assign pop       = cmd_valid && cmd_ready && !flush;
    assign push_req  = key_valid && key_legal && !flush;
    assign push      = push_req && (!full || pop);
    assign drop_ev   = push_req && full && !pop;
    assign reject_ev = key_valid && !key_legal;

    // Command storage; contents are not reset, validity comes from fifo_count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_word;
        end
    end

    // Read/write pointers, wrapping modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: +1 on push only, -1 on pop only
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fifo_count <= '0;
        end else if (push && !pop) begin
            fifo_count <= fifo_count + 1'b1;
        end else if (pop && !push) begin
            fifo_count <= fifo_count - 1'b1;
        end
    end

    // Command address of the head, advancing on each pop and wrapping at ADDR_LIMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr <= '0;
        end else if (pop) begin
            cmd_addr <= (cmd_addr == ADDR_MAX) ? '0 : cmd_addr + 16'd1;
        end
    end

    // Saturating reject and drop event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            reject_count <= '0;
            drop_count   <= '0;
        end else begin
            if (reject_ev && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
            if (drop_ev && drop_count != 8'hFF)     drop_count   <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmd_encoder.sv
// Testbench for cmd_encoder: scenario tasks with a command-word scoreboard.
module tb_cmd_encoder;

    localparam int DEPTH      = 8;
    localparam int ADDR_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        on_enemy;
    logic        can_hacks;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [15:0] cmd_addr;
    logic [3:0]  fifo_count;
    logic [7:0]  reject_count;
    logic [7:0]  drop_count;

    int          n_checks;
    int          n_fail;

    logic [15:0] exp_q[$];
    int          m_addr;
    int          m_rej;
    int          m_drop;

    cmd_encoder #(
        .DEPTH      (DEPTH),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .on_enemy     (on_enemy),
        .can_hacks    (can_hacks),
        .flush        (flush),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_addr     (cmd_addr),
        .fifo_count   (fifo_count),
        .reject_count (reject_count),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic legal(input logic [3:0] kc, input logic oe, input logic ch);
        if (kc >= 4'd1 && kc <= 4'd4) return !oe;
        if (kc == 4'd5 || kc == 4'd6) return oe;
        if (kc == 4'hA)               return ch;
        return 1'b0;
    endfunction

    function automatic logic [15:0] word_of(input logic [3:0] kc);
        return (kc == 4'hA) ? 16'h0010 : {12'h000, kc};
    endfunction

    // One clock of stimulus: apply inputs at the falling edge, update the
    // reference model, check any pop against the scoreboard head, then return
    // at the next falling edge with outputs settled.
    task automatic drive(input logic r, input logic kv, input logic [3:0] kc,
                         input logic oe, input logic ch, input logic fl, input logic rdy);
        logic m_pop;
        rst = r; key_valid = kv; key_code = kc; on_enemy = oe;
        can_hacks = ch; flush = fl; cmd_ready = rdy;
        #1;
        if (r) begin
            exp_q.delete();
            m_addr = 0; m_rej = 0; m_drop = 0;
        end else begin
            m_pop = (exp_q.size() != 0) && rdy && !fl;
            if (m_pop) begin
                n_checks++;
                if (cmd_valid !== 1'b1 || cmd_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h",
                             cmd_valid, cmd_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                m_addr = (m_addr == ADDR_LIMIT - 1) ? 0 : m_addr + 1;
            end
            if (kv && !legal(kc, oe, ch)) begin
                if (m_rej != 255) m_rej++;
            end else if (kv && !fl) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(word_of(kc));
                else if (m_drop != 255)   m_drop++;
            end
            if (fl) exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic key(input logic [3:0] kc, input logic oe, input logic ch, input logic rdy);
        drive(1'b0, 1'b1, kc, oe, ch, 1'b0, rdy);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 4'd0 || cmd_addr !== 16'd0 ||
            reject_count !== 8'd0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: got valid=%b count=%0d addr=%0d rej=%0d drop=%0d, expected all 0",
                     cmd_valid, fifo_count, cmd_addr, reject_count, drop_count);
        end
    endtask

    task automatic test_basic();
        key(4'h3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 16'h0003 || cmd_addr !== 16'd0 || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_push: got valid=%b data=%h addr=%0d count=%0d, expected 1 0003 0 1",
                     cmd_valid, cmd_data, cmd_addr, fifo_count);
        end
        idle(1'b0);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 16'h0003) begin
            n_fail++;
            $display("FAIL basic_hold: got valid=%b data=%h, expected 1 0003", cmd_valid, cmd_data);
        end
        idle(1'b1);
        n_checks++;
        if (cmd_valid !== 1'b0 || cmd_addr !== 16'd1 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_pop: got valid=%b addr=%0d count=%0d, expected 0 1 0",
                     cmd_valid, cmd_addr, fifo_count);
        end
    endtask

    task automatic test_filter();
        key(4'h5, 1'b0, 1'b0, 1'b0);
        key(4'h9, 1'b0, 1'b0, 1'b0);
        key(4'hA, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (reject_count !== 8'd3 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL filter_reject: got rej=%0d count=%0d, expected 3 0", reject_count, fifo_count);
        end
        key(4'h6, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cmd_data !== 16'h0006 || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL filter_run: got data=%h count=%0d, expected 0006 1", cmd_data, fifo_count);
        end
        // mode flips after queuing: queued run command must not be re-filtered
        key(4'hA, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 4'd2 || reject_count !== 8'd3 || cmd_data !== 16'h0006) begin
            n_fail++;
            $display("FAIL filter_shroud: got count=%0d rej=%0d head=%h, expected 2 3 0006",
                     fifo_count, reject_count, cmd_data);
        end
        idle(1'b1);
        idle(1'b1);
        n_checks++;
        if (cmd_valid !== 1'b0 || cmd_addr !== 16'd3) begin
            n_fail++;
            $display("FAIL filter_drain: got valid=%b addr=%0d, expected 0 3", cmd_valid, cmd_addr);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int unsigned i = 0; i < 9; i++) key(4'((i % 4) + 1), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fifo_count !== 4'd8 || drop_count !== 8'd1 || cmd_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL full_drop: got count=%0d drop=%0d head=%h, expected 8 1 0001",
                     fifo_count, drop_count, cmd_data);
        end
        key(4'h2, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (fifo_count !== 4'd8 || drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL full_pushpop: got count=%0d drop=%0d, expected 8 1", fifo_count, drop_count);
        end
        for (int unsigned i = 0; i < 8; i++) idle(1'b1);
        n_checks++;
        if (fifo_count !== 4'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: got count=%0d, expected 0 (model left %0d)", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] seq [6];
        seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        do_reset();
        for (int unsigned i = 0; i < 5; i++) begin
            key(4'h4, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (cmd_addr !== seq[i] || cmd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL addr_wrap[%0d]: got addr=%0d valid=%b, expected %0d 1", i, cmd_addr, cmd_valid, seq[i]);
            end
            idle(1'b1);
        end
        n_checks++;
        if (cmd_addr !== seq[5] || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_wrap_end: got addr=%0d valid=%b, expected 1 0", cmd_addr, cmd_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        key(4'h7, 1'b0, 1'b0, 1'b0);
        key(4'h1, 1'b0, 1'b0, 1'b0);
        key(4'h2, 1'b0, 1'b0, 1'b0);
        key(4'h3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (fifo_count !== 4'd0 || cmd_valid !== 1'b0 || cmd_addr !== 16'd0 ||
            drop_count !== 8'd0 || reject_count !== 8'd1) begin
            n_fail++;
            $display("FAIL flush: got count=%0d valid=%b addr=%0d drop=%0d rej=%0d, expected 0 0 0 0 1",
                     fifo_count, cmd_valid, cmd_addr, drop_count, reject_count);
        end
        key(4'h1, 1'b0, 1'b0, 1'b0);
        key(4'h2, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        n_checks++;
        if (cmd_addr !== 16'd1 || cmd_data !== 16'h0002 || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_reuse: got addr=%0d data=%h count=%0d, expected 1 0002 1",
                     cmd_addr, cmd_data, fifo_count);
        end
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 4'd0 || cmd_addr !== 16'd0 ||
            reject_count !== 8'd0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b count=%0d addr=%0d rej=%0d drop=%0d, expected all 0",
                     cmd_valid, fifo_count, cmd_addr, reject_count, drop_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int unsigned i = 0; i < 12; i++) key(4'((i % 6) + 1), (i % 6) >= 4, 1'b0, 1'b1);
        idle(1'b1);
        n_checks++;
        if (cmd_valid !== 1'b0 || cmd_addr !== 16'(m_addr) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back: got valid=%b addr=%0d, expected 0 %0d", cmd_valid, cmd_addr, m_addr);
        end
    endtask

    task automatic test_random();
        logic kv, oe, ch, fl, rdy;
        logic [3:0] kc;
        do_reset();
        for (int unsigned i = 0; i < 400; i++) begin
            kv  = ($urandom_range(3) != 0);
            kc  = 4'($urandom_range(15));
            oe  = 1'($urandom_range(1));
            ch  = 1'($urandom_range(1));
            fl  = ($urandom_range(24) == 0);
            rdy = ($urandom_range(2) == 0);
            drive(1'b0, kv, kc, oe, ch, fl, rdy);
            n_checks++;
            if (cmd_valid !== (exp_q.size() != 0) || fifo_count !== 4'(exp_q.size()) ||
                cmd_addr !== 16'(m_addr) || reject_count !== 8'(m_rej) || drop_count !== 8'(m_drop)) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b c=%0d a=%0d r=%0d d=%0d, expected v=%b c=%0d a=%0d r=%0d d=%0d",
                         i, cmd_valid, fifo_count, cmd_addr, reject_count, drop_count,
                         exp_q.size() != 0, exp_q.size(), m_addr, m_rej, m_drop);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int unsigned i = 0; i < 260; i++) key(4'hF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (reject_count !== 8'd255) begin
            n_fail++;
            $display("FAIL reject_sat: got %0d, expected 255", reject_count);
        end
        for (int unsigned i = 0; i < 268; i++) key(4'h1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (drop_count !== 8'd255 || fifo_count !== 4'd8 || reject_count !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_sat: got drop=%0d count=%0d rej=%0d, expected 255 8 255",
                     drop_count, fifo_count, reject_count);
        end
        do_reset();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_addr = 0; m_rej = 0; m_drop = 0;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; on_enemy = 1'b0;
        can_hacks = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_filter();
        test_full();
        test_addr_wrap();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_encoder.md
Name: cmd_encoder

Overview:
- Producer end of the engine command stream: turns raw keypad codes into the 16-bit command words the engine consumes (1 right, 2 left, 3 up, 4 down, 5 attack, 6 run, 16'h0010 shroud toggle).
- Filters each key against the current game mode and buffers legal commands in a FIFO.
- Presents commands to the engine over a valid/ready handshake with a running command address that mirrors the engine's command pointer.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2).
- ADDR_LIMIT, 2001, command-buffer size; cmd_addr wraps from ADDR_LIMIT-1 to 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_code is present.
- key_code  in  4  keypad code: 1–6, or 4'hA for the shroud toggle.
- on_enemy  in  1  engine is in combat mode.
- can_hacks  in  1  cheat commands enabled.
- flush  in  1  discard all queued commands.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ready  in  1  engine takes the head this cycle.
- cmd_data  out  16  command word at the FIFO head.
- cmd_addr  out  16  buffer index of the current head command.
- fifo_count  out  $clog2(DEPTH)+1  number of entries held.
- reject_count  out  8  illegal keys, saturating at 255.
- drop_count  out  8  legal keys lost to a full FIFO, saturating at 255.

Behaviour:
- Clock and reset:
  - One clock domain, clk only.
  - Reset is synchronous and active-high on rst.
  - rst clears read/write pointers and all counters; cmd_valid=0, cmd_addr=0, fifo_count=0, reject/drop=0.
  - Reset has priority over every other input.
  - FIFO storage is not cleared; cmd_data is don't-care while cmd_valid=0.
- Legality (combinational on key_code, on_enemy, can_hacks):
  - Codes 1–4 are legal only when on_enemy=0.
  - Codes 5 and 6 are legal only when on_enemy=1.
  - Code 4'hA is legal only when can_hacks=1.
  - All other codes (0, 7–9, B–F) are illegal.
- Mapping: codes 1–6 map to zero-extended 16'h0001–16'h0006; 4'hA maps to 16'h0010.
- Push:
  - Occurs when key_valid, the key is legal, and no flush.
  - If the FIFO is full and there is no simultaneous pop: the key is dropped and drop_count increments (saturating).
  - If the FIFO is full and pop occurs in the same cycle: the push is accepted and count is unchanged.
- Reject: key_valid with an illegal code increments reject_count (saturating). Nothing is enqueued.
- Pop: occurs when cmd_valid && cmd_ready. rd_ptr advances; cmd_addr increments, wrapping ADDR_LIMIT-1 → 0.
- Output and latency:
  - cmd_valid = (fifo_count != 0).
  - cmd_data is read from the FIFO head register array; there is no fall-through.
  - A key accepted at edge N into an empty FIFO gives cmd_valid=1 after edge N, i.e. visible in cycle N+1.
  - Push into an empty FIFO with cmd_ready=1 does not pop that cycle.
  - cmd_data and cmd_valid stay stable while cmd_valid && !cmd_ready.
- Pointers: wrap modulo DEPTH. fifo_count updates +1 on push only, -1 on pop only, unchanged on both or neither.
- flush:
  - Sets rd_ptr=wr_ptr and fifo_count=0 next cycle.
  - A key arriving in the same cycle is discarded and not counted as a drop.
  - A pop in the same cycle is ignored; cmd_addr is not incremented.
  - reject_count, drop_count and cmd_addr keep their values.
- Mode changes: on_enemy and can_hacks are sampled only in the key_valid cycle. Queued commands are never re-filtered.
- Counters: 8-bit, hold at 255, cleared only by rst.

Test Plan:
- Reset, on_enemy=0, key 3 pulse, cmd_ready=0 → cycle+1: cmd_valid=1, cmd_data=16'h0003, cmd_addr=0, fifo_count=1; raise cmd_ready → next cycle cmd_valid=0, cmd_addr=1.
- on_enemy=0: keys 5, 9, then A with can_hacks=0 → reject_count=3, fifo_count=0; on_enemy=1 key 6 → cmd_data=16'h0006; can_hacks=1 key A → 16'h0010 queued second.
- cmd_ready=0, push 9 legal keys with DEPTH=8 → fifo_count=8, drop_count=1; drain → 8 words in push order.
- FIFO full, key 1 pushed with cmd_ready=1 in the same cycle → fifo_count stays 8, drop_count unchanged, new word appears last.
- ADDR_LIMIT=4, 5 push/pop pairs → cmd_addr sequence 0,1,2,3,0,1.
- 3 entries queued, flush with a simultaneous key and cmd_ready=1 → fifo_count=0, cmd_valid=0, cmd_addr unchanged, drop_count unchanged; rst asserted mid-drain → all outputs at reset values next cycle.
